// File: rtl/itm_swo_tx_pkg.sv
// Shared ITM framing constants, payload size codes, FSM states and FIFO entry layout
// for the SWO trace transmitter.
package itm_swo_tx_pkg;

  localparam int         SYNC_ZERO_BYTES = 5;
  localparam logic [7:0] SYNC_TAIL       = 8'h80;
  localparam logic [7:0] OVF_BYTE        = 8'h70;
  localparam int         UART_LAST_BIT   = 9;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_1B   = 2'b01,
    SZ_2B   = 2'b10,
    SZ_4B   = 2'b11
  } itm_size_e;

  // state | meaning
  // IDLE  | choose next packet: sync, then overflow, then FIFO
  // SYNC  | five 0x00 bytes then 0x80
  // OVF   | single overflow byte
  // HDR   | header of the popped entry
  // PAY   | payload bytes, LSB first
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    OVF,
    HDR,
    PAY
  } itm_state_e;

  typedef struct packed {
    logic [4:0]  port;
    logic [1:0]  size;
    logic [31:0] data;
  } itm_entry_t;

  function automatic logic [2:0] payload_len(input logic [1:0] size);
    case (size)
      SZ_1B:   payload_len = 3'd1;
      SZ_2B:   payload_len = 3'd2;
      SZ_4B:   payload_len = 3'd4;
      default: payload_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/swo_uart_byte_tx.sv
// NRZ byte serialiser: start bit, 8 data bits LSB first, stop bit, each bit held
// prescaler+1 cycles. ready covers the final stop cycle so bytes chain without a gap.
module swo_uart_byte_tx
  import itm_swo_tx_pkg::*;
#(
  parameter int pDIV_WIDTH = 16
) (
  input  logic                  fe_clk,
  input  logic                  reset_n,
  input  logic [pDIV_WIDTH-1:0] prescaler,
  input  logic [7:0]            tx_byte,
  input  logic                  load,
  output logic                  ready,
  output logic                  end_of_byte,
  output logic                  busy,
  output logic                  line
);

  logic [8:0]            shreg;
  logic [3:0]            bit_idx;
  logic [pDIV_WIDTH-1:0] pcnt;
  logic [pDIV_WIDTH-1:0] period;
  logic                  last_cycle;

  assign last_cycle  = busy && (bit_idx == 4'(UART_LAST_BIT)) && (pcnt == '0);
  assign ready       = !busy || last_cycle;
  assign end_of_byte = last_cycle;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      shreg   <= '1;
      bit_idx <= '0;
      pcnt    <= '0;
      period  <= '0;
      line    <= 1'b1;
    end else if (load && ready) begin
      // prescaler is captured here so a mid-byte change cannot distort the frame
      busy    <= 1'b1;
      shreg   <= {1'b1, tx_byte};
      bit_idx <= '0;
      pcnt    <= prescaler;
      period  <= prescaler;
      line    <= 1'b0;
    end else if (busy) begin
      if (pcnt != '0) begin
        pcnt <= pcnt - 1'b1;
      end else if (last_cycle) begin
        busy <= 1'b0;
        line <= 1'b1;
      end else begin
        line    <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_idx <= bit_idx + 4'd1;
        pcnt    <= period;
      end
    end
  end

endmodule

// File: rtl/itm_swo_tx.sv
// ITM software-source packet formatter with write FIFO, periodic/enable-triggered sync
// and overflow packets, driving a single SWO NRZ line.
module itm_swo_tx
  import itm_swo_tx_pkg::*;
#(
  parameter int pFIFO_DEPTH = 16,
  parameter int pDIV_WIDTH  = 16,
  parameter int pSYNC_WIDTH = 16
) (
  input  logic                   fe_clk,
  input  logic                   reset_n,
  input  logic                   I_enable,
  input  logic [pDIV_WIDTH-1:0]  I_prescaler,
  input  logic [pSYNC_WIDTH-1:0] I_sync_period,
  input  logic                   I_wr,
  input  logic [4:0]             I_port,
  input  logic [1:0]             I_size,
  input  logic [31:0]            I_data,
  input  logic                   I_clear_ovf,
  output logic                   O_full,
  output logic                   O_ovf_sticky,
  output logic                   O_busy,
  output logic                   O_pkt_done,
  output logic                   O_swo
);

  localparam int         AW            = $clog2(pFIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(pFIFO_DEPTH);

  itm_entry_t             mem [pFIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [AW:0]            fifo_cnt;
  logic                   empty, push_req, push_ok, drop, pop;

  itm_state_e             state, state_n;
  logic [2:0]             idx, idx_n;
  itm_entry_t             cur;
  logic [7:0]             tx_byte, pay_byte;
  logic                   load, tx_ready, tx_end, tx_busy;

  logic                   sync_due, ovf_pending, en_q, en_rise, period_hit, sync_req;
  logic [pSYNC_WIDTH-1:0] byte_cnt;
  logic                   sync_clr, ovf_clr, cnt_inc, last_pay, pend_done;

  assign O_full   = (fifo_cnt == FIFO_FULL_CNT);
  assign empty    = (fifo_cnt == '0);
  assign push_req = I_wr && (I_size != SZ_NONE);
  assign push_ok  = push_req && !O_full;
  assign drop     = push_req && O_full;

  always_ff @(posedge fe_clk) begin
    if (push_ok) mem[wptr] <= {I_port, I_size, I_data};
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      cur      <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        cur  <= mem[rptr];
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign en_rise    = I_enable && !en_q;
  assign period_hit = (I_sync_period != '0) && (byte_cnt >= I_sync_period);
  // combinational so a threshold crossed by the last byte of a packet wins at once
  assign sync_req   = sync_due || en_rise || period_hit;

  always_comb begin
    case (idx[1:0])
      2'd0:    pay_byte = cur.data[7:0];
      2'd1:    pay_byte = cur.data[15:8];
      2'd2:    pay_byte = cur.data[23:16];
      default: pay_byte = cur.data[31:24];
    endcase
  end

  // The FSM leaves each packet as soon as its last byte is loaded, so IDLE decides
  // the next packet while that byte is still on the wire.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    load     = 1'b0;
    tx_byte  = 8'h00;
    pop      = 1'b0;
    sync_clr = 1'b0;
    ovf_clr  = 1'b0;
    cnt_inc  = 1'b0;
    last_pay = 1'b0;
    case (state)
      IDLE: begin
        if (I_enable) begin
          if (sync_req) begin
            state_n = SYNC;
            idx_n   = 3'd0;
          end else if (ovf_pending) begin
            state_n = OVF;
          end else if (!empty) begin
            state_n = HDR;
            pop     = 1'b1;
          end
        end
      end
      SYNC: begin
        if (tx_ready) begin
          load = 1'b1;
          if (idx == 3'(SYNC_ZERO_BYTES)) begin
            tx_byte  = SYNC_TAIL;
            sync_clr = 1'b1;
            state_n  = IDLE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      OVF: begin
        if (tx_ready) begin
          load    = 1'b1;
          tx_byte = OVF_BYTE;
          ovf_clr = 1'b1;
          cnt_inc = 1'b1;
          state_n = IDLE;
        end
      end
      HDR: begin
        if (tx_ready) begin
          load    = 1'b1;
          tx_byte = {cur.port, 1'b0, cur.size};
          cnt_inc = 1'b1;
          idx_n   = 3'd0;
          state_n = PAY;
        end
      end
      PAY: begin
        if (tx_ready) begin
          load    = 1'b1;
          tx_byte = pay_byte;
          cnt_inc = 1'b1;
          if (idx == payload_len(cur.size) - 3'd1) begin
            last_pay = 1'b1;
            state_n  = IDLE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      en_q         <= 1'b0;
      sync_due     <= 1'b1;
      ovf_pending  <= 1'b0;
      O_ovf_sticky <= 1'b0;
      byte_cnt     <= '0;
      pend_done    <= 1'b0;
      O_pkt_done   <= 1'b0;
      O_busy       <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      en_q         <= I_enable;
      sync_due     <= en_rise || (!sync_clr && (sync_due || period_hit));
      ovf_pending  <= drop || (ovf_pending && !ovf_clr);
      O_ovf_sticky <= drop || (O_ovf_sticky && !I_clear_ovf);
      if (sync_clr) begin
        byte_cnt <= '0;
      end else if (cnt_inc && (byte_cnt != '1)) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      // last payload byte is tracked until its stop bit actually ends
      pend_done  <= last_pay || (pend_done && !tx_end);
      O_pkt_done <= pend_done && tx_end;
      O_busy     <= tx_busy || (state != IDLE) || !empty || ovf_pending
                    || (I_enable && sync_req);
    end
  end

  swo_uart_byte_tx #(
    .pDIV_WIDTH(pDIV_WIDTH)
  ) u_uart (
    .fe_clk     (fe_clk),
    .reset_n    (reset_n),
    .prescaler  (I_prescaler),
    .tx_byte    (tx_byte),
    .load       (load),
    .ready      (tx_ready),
    .end_of_byte(tx_end),
    .busy       (tx_busy),
    .line       (O_swo)
  );

endmodule

// File: tb/tb_itm_swo_tx.sv
// Self-checking bench for itm_swo_tx: a line monitor decodes SWO frames and compares
// them against an expected-byte queue filled as stimulus is applied.
module tb_itm_swo_tx;

  logic        fe_clk;
  logic        reset_n;
  logic        I_enable;
  logic [15:0] I_prescaler;
  logic [15:0] I_sync_period;
  logic        I_wr;
  logic [4:0]  I_port;
  logic [1:0]  I_size;
  logic [31:0] I_data;
  logic        I_clear_ovf;
  logic        O_full, O_ovf_sticky, O_busy, O_pkt_done, O_swo;

  itm_swo_tx #(
    .pFIFO_DEPTH(16),
    .pDIV_WIDTH (16),
    .pSYNC_WIDTH(16)
  ) dut (
    .fe_clk       (fe_clk),
    .reset_n      (reset_n),
    .I_enable     (I_enable),
    .I_prescaler  (I_prescaler),
    .I_sync_period(I_sync_period),
    .I_wr         (I_wr),
    .I_port       (I_port),
    .I_size       (I_size),
    .I_data       (I_data),
    .I_clear_ovf  (I_clear_ovf),
    .O_full       (O_full),
    .O_ovf_sticky (O_ovf_sticky),
    .O_busy       (O_busy),
    .O_pkt_done   (O_pkt_done),
    .O_swo        (O_swo)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         rx_count = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  bit         mon_act = 0;
  int         mon_t, mon_p, mon_k;
  logic [7:0] mon_byte;

  typedef struct {
    logic [4:0]  port;
    logic [1:0]  size;
    logic [31:0] data;
    int          n;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge fe_clk) cyc++;

  always @(negedge fe_clk) begin
    if (reset_n && O_pkt_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // UART line monitor: mid-bit sampling, LSB first
  always @(negedge fe_clk) begin
    if (!reset_n) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (O_swo == 1'b0) begin
        mon_act = 1;
        mon_t   = 0;
        mon_p   = int'(I_prescaler) + 1;
        starts.push_back(cyc);
      end
    end else begin
      mon_t++;
      if ((mon_t % mon_p) == (mon_p / 2)) begin
        mon_k = mon_t / mon_p;
        if (mon_k >= 1 && mon_k <= 8) begin
          mon_byte = {O_swo, mon_byte[7:1]};
        end else if (mon_k == 9) begin
          mon_act = 0;
          rx_count++;
          chk("stop_bit", O_swo, 1);
          if (exp_q.size() == 0) chk("rx_unexpected", mon_byte, 'h1ff);
          else chk("rx_byte", mon_byte, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [4:0] p, input logic [1:0] s, input logic [31:0] d);
    @(negedge fe_clk);
    I_port = p; I_size = s; I_data = d; I_wr = 1'b1;
    @(posedge fe_clk);
    #1 I_wr = 1'b0;
  endtask

  task automatic expect_pkt(input logic [4:0] p, input logic [1:0] s, input logic [31:0] d);
    int n;
    n = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : (s == 2'b11) ? 4 : 0;
    if (n == 0) return;
    exp_q.push_back({p, 1'b0, s});
    for (int j = 0; j < n; j++) exp_q.push_back(d[8*j +: 8]);
  endtask

  task automatic expect_sync();
    for (int j = 0; j < 5; j++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || O_busy || mon_act) && n < 20000) begin
      @(negedge fe_clk);
      n++;
    end
    repeat (3) @(negedge fe_clk);
    chk({name, "_timeout"}, (n < 20000), 1);
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_rx(input int target, input string name);
    int n = 0;
    while (rx_count < target && n < 5000) begin
      @(negedge fe_clk);
      n++;
    end
    chk(name, (n < 5000), 1);
  endtask

  initial begin
    int base, lows, d0;
    vecs[0] = '{5'd5,  2'b10, 32'h0000BEEF, 3, 40'h00_00_BE_EF_2A};
    vecs[1] = '{5'd31, 2'b11, 32'h12345678, 5, 40'h12_34_56_78_FB};
    vecs[2] = '{5'd0,  2'b01, 32'h00000041, 2, 40'h00_00_00_41_01};
    vecs[3] = '{5'd1,  2'b01, 32'hFFFFFF80, 2, 40'h00_00_00_80_09};
    vecs[4] = '{5'd16, 2'b10, 32'h1234A55A, 3, 40'h00_00_A5_5A_82};
    vecs[5] = '{5'd2,  2'b00, 32'hFFFFFFFF, 0, 40'h0};
    vecs[6] = '{5'd7,  2'b11, 32'hDEADBEEF, 5, 40'hDE_AD_BE_EF_3B};

    reset_n = 1'b0; I_enable = 1'b0; I_prescaler = 16'd3; I_sync_period = 16'd0;
    I_wr = 1'b0; I_port = '0; I_size = '0; I_data = '0; I_clear_ovf = 1'b0;
    repeat (3) @(posedge fe_clk);
    #1;
    chk("rst_swo", O_swo, 1);
    chk("rst_full", O_full, 0);
    chk("rst_ovf", O_ovf_sticky, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_pkt_done", O_pkt_done, 0);
    @(negedge fe_clk) reset_n = 1'b1;

    // enable rising edge: sync then the first packet, gap-free
    starts.delete();
    done_cnt = 0;
    expect_sync();
    expect_pkt(5'd0, 2'b01, 32'h41);
    @(negedge fe_clk) I_enable = 1'b1;
    push(5'd0, 2'b01, 32'h41);
    drain("t1");
    chk("t1_nbytes", starts.size(), 8);
    chk("t1_span", (starts.size() >= 8) ? starts[7] - starts[0] : -1, 280);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc - ((starts.size() >= 8) ? starts[7] : 0), 40);

    // table of packets; the first also checks write-to-start-bit latency
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].exp[8*j +: 8]);
      push(vecs[i].port, vecs[i].size, vecs[i].data);
      if (i == 0) begin
        @(posedge fe_clk);
        #1 chk("lat_edge1_high", O_swo, 1);
        @(posedge fe_clk);
        #1 chk("lat_edge2_start", O_swo, 0);
      end
    end
    drain("tbl");
    chk("tbl_done_cnt", done_cnt, 6);

    // overflow: fill while disabled, one push dropped
    @(negedge fe_clk) I_enable = 1'b0;
    for (int i = 0; i < 16; i++) push(5'(i), 2'b01, 32'(i + 8'hA0));
    chk("ovf_full", O_full, 1);
    chk("ovf_sticky_before_drop", O_ovf_sticky, 0);
    push(5'd20, 2'b01, 32'h99);
    chk("ovf_sticky_set", O_ovf_sticky, 1);
    chk("ovf_busy_disabled", O_busy, 1);
    done_cnt = 0;
    expect_sync();
    exp_q.push_back(8'h70);
    for (int i = 0; i < 16; i++) expect_pkt(5'(i), 2'b01, 32'(i + 8'hA0));
    @(negedge fe_clk) I_enable = 1'b1;
    drain("ovf");
    chk("ovf_done_cnt", done_cnt, 16);
    chk("ovf_full_after", O_full, 0);
    chk("ovf_sticky_held", O_ovf_sticky, 1);
    @(negedge fe_clk) I_clear_ovf = 1'b1;
    @(posedge fe_clk);
    #1 I_clear_ovf = 1'b0;
    chk("ovf_sticky_cleared", O_ovf_sticky, 0);

    // periodic sync: counter already past 4, then only at a packet boundary
    expect_sync();
    @(negedge fe_clk) I_sync_period = 16'd4;
    drain("per_first");
    expect_pkt(5'd3, 2'b01, 32'h11);
    expect_pkt(5'd4, 2'b01, 32'h22);
    expect_sync();
    expect_pkt(5'd6, 2'b01, 32'h33);
    push(5'd3, 2'b01, 32'h11);
    push(5'd4, 2'b01, 32'h22);
    push(5'd6, 2'b01, 32'h33);
    drain("per");
    @(negedge fe_clk) I_sync_period = 16'd0;

    // disable during payload of a 4-byte packet
    base = rx_count;
    expect_pkt(5'd9, 2'b11, 32'hCAFEF00D);
    push(5'd9, 2'b11, 32'hCAFEF00D);
    push(5'd12, 2'b01, 32'h5C);
    wait_rx(base + 2, "dis_wait_payload");
    @(negedge fe_clk) I_enable = 1'b0;
    wait_rx(base + 5, "dis_wait_complete");
    repeat (20) @(negedge fe_clk);
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge fe_clk);
      if (!O_swo) lows++;
    end
    chk("dis_line_idle", lows, 0);
    chk("dis_bytes", rx_count - base, 5);
    chk("dis_busy_fifo", O_busy, 1);
    expect_sync();
    expect_pkt(5'd12, 2'b01, 32'h5C);
    @(negedge fe_clk) I_enable = 1'b1;
    drain("reen");

    // reset in the middle of a byte
    base = rx_count;
    d0 = done_cnt;
    expect_pkt(5'd1, 2'b11, 32'h01020304);
    push(5'd1, 2'b11, 32'h01020304);
    wait_rx(base + 1, "rst_wait_hdr");
    repeat (10) @(posedge fe_clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_swo", O_swo, 1);
    chk("midrst_busy", O_busy, 0);
    chk("midrst_full", O_full, 0);
    repeat (3) @(negedge fe_clk);
    exp_q.delete();
    expect_sync();
    expect_pkt(5'd2, 2'b01, 32'h77);
    reset_n = 1'b1;
    push(5'd2, 2'b01, 32'h77);
    drain("post_rst");
    chk("post_rst_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
